// File: rtl/servo_pwm.sv
// Memory-mapped servo PWM generator with double-buffered PERIOD/WIDTH shadows.
// Optional build macro SERVO_PWM_LIMIT_EN clamps WIDTH writes to [W_MIN, W_MAX].
module servo_pwm #(
    parameter int unsigned PERIOD_RST = 1_000_000,
    parameter int unsigned WIDTH_RST  = 75_000,
    parameter int unsigned W_MIN      = 50_000,
    parameter int unsigned W_MAX      = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        MemWrite,
    input  logic [1:0]  DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] rd_data,
    output logic        m_servo
);
    localparam logic [23:0] PER_RST_C = 24'(PERIOD_RST);
    localparam logic [23:0] WID_RST_C = 24'(WIDTH_RST);
    localparam logic [23:0] W_MIN_C   = 24'(W_MIN);
    localparam logic [23:0] W_MAX_C   = 24'(W_MAX);
    localparam logic [23:0] PER_MIN_C = 24'd2;

`ifdef SERVO_PWM_LIMIT_EN
    function automatic logic [23:0] wid_store(input logic [23:0] v);
        logic [23:0] r;
        if (v < W_MIN_C) begin
            r = W_MIN_C;
        end else if (v > W_MAX_C) begin
            r = W_MAX_C;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic unused_s;
    assign unused_s = ^WriteData[31:24];
`else
    function automatic logic [23:0] wid_store(input logic [23:0] v);
        return v;
    endfunction

    logic unused_s;
    assign unused_s = ^{WriteData[31:24], W_MIN_C, W_MAX_C};
`endif

    logic        en_r;
    logic        pend_r;
    logic [23:0] period_r;
    logic [23:0] width_r;
    logic [23:0] per_a_r;
    logic [23:0] wid_a_r;
    logic [23:0] cnt_r;
    logic        m_servo_r;

    logic        wr_s;
    logic        wrap_s;
    logic [23:0] per_wr_s;
    logic [23:0] wid_wr_s;

    assign wr_s    = !cs && MemWrite;
    assign wrap_s  = en_r && (cnt_r == (per_a_r - 24'd1));
    assign m_servo = m_servo_r;

    // Write-data conditioning: period floor of 2 and optional width clamp.
    always_comb begin
        per_wr_s = WriteData[23:0];
        wid_wr_s = wid_store(WriteData[23:0]);
        if (WriteData[23:0] < PER_MIN_C) begin
            per_wr_s = PER_MIN_C;
        end else begin
            per_wr_s = WriteData[23:0];
        end
    end

    // Register file, shadow reload, counter and registered pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_r      <= 1'b0;
            pend_r    <= 1'b0;
            period_r  <= PER_RST_C;
            width_r   <= WID_RST_C;
            per_a_r   <= PER_RST_C;
            wid_a_r   <= WID_RST_C;
            cnt_r     <= 24'd0;
            m_servo_r <= 1'b0;
        end else begin
            m_servo_r <= en_r && (cnt_r < wid_a_r);
            if (wrap_s) begin
                cnt_r   <= 24'd0;
                per_a_r <= period_r;
                wid_a_r <= width_r;
                pend_r  <= 1'b0;
            end else if (en_r) begin
                cnt_r <= cnt_r + 24'd1;
            end else begin
                cnt_r <= 24'd0;
            end
            // Later bus assignments override the wrap: a same-cycle write stays pending.
            if (wr_s) begin
                case (DataAdr)
                    2'd0: begin
                        en_r <= WriteData[0];
                        if (WriteData[0] && !en_r) begin
                            cnt_r   <= 24'd0;
                            per_a_r <= period_r;
                            wid_a_r <= width_r;
                            pend_r  <= 1'b0;
                        end else if (!WriteData[0]) begin
                            cnt_r <= 24'd0;
                        end
                    end
                    2'd1: begin
                        period_r <= per_wr_s;
                        pend_r   <= 1'b1;
                    end
                    2'd2: begin
                        width_r <= wid_wr_s;
                        pend_r  <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Combinational read mux, zero unless selected for a read.
    always_comb begin
        rd_data = 32'h0;
        if (!cs && !MemWrite) begin
            case (DataAdr)
                2'd0:    rd_data = {31'd0, en_r};
                2'd1:    rd_data = {8'd0, period_r};
                2'd2:    rd_data = {8'd0, width_r};
                default: rd_data = {cnt_r, 6'd0, pend_r, en_r};
            endcase
        end else begin
            rd_data = 32'h0;
        end
    end
endmodule

// File: tb/tb_servo_pwm.sv
// Scoreboard bench for servo_pwm: a waveform-queue reference model predicts the pin and reads.
module tb_servo_pwm;
    localparam int P_RST = 10;
    localparam int W_RST = 3;
    localparam int WMIN  = 2;
    localparam int WMAX  = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        MemWrite;
    logic [1:0]  DataAdr;
    logic [31:0] WriteData;
    logic [31:0] rd_data;
    logic        m_servo;

    servo_pwm #(
        .PERIOD_RST(P_RST),
        .WIDTH_RST (W_RST),
        .W_MIN     (WMIN),
        .W_MAX     (WMAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .rd_data  (rd_data),
        .m_servo  (m_servo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit          pin_q[$];
    logic [31:0] rd_q[$];
    bit          e_pin;
    logic [31:0] e_rd;

    // Reference model: registers plus the remaining samples of the current period.
    bit m_en;
    bit m_pend;
    int m_per;
    int m_wid;
    int a_per;
    int a_wid;
    bit wave[$];

    function automatic void refill();
        wave.delete();
        for (int i = 0; i < a_per; i++) wave.push_back(i < a_wid);
    endfunction

    function automatic void model_reset();
        m_en = 0; m_pend = 0;
        m_per = P_RST; m_wid = W_RST;
        a_per = P_RST; a_wid = W_RST;
        wave.delete();
    endfunction

    function automatic int model_cnt();
        return m_en ? (a_per - wave.size()) : 0;
    endfunction

    function automatic int wid_store(input int v);
`ifdef SERVO_PWM_LIMIT_EN
        if (v < WMIN) return WMIN;
        if (v > WMAX) return WMAX;
        return v;
`else
        return v;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] cv;
        cv = 32'(model_cnt());
        case (a)
            2'd0:    return {31'd0, m_en};
            2'd1:    return 32'(m_per);
            2'd2:    return 32'(m_wid);
            default: return {cv[23:0], 6'd0, m_pend, m_en};
        endcase
    endfunction

    // One bus cycle: predict read and pin, then let the edge happen.
    task automatic cycle(input bit rst, input bit c, input bit we,
                         input logic [1:0] a, input logic [31:0] d);
        bit exp_pin;
        int v;
        reset = rst; cs = c; MemWrite = we; DataAdr = a; WriteData = d;
        rd_q.push_back((!c && !we) ? model_read(a) : 32'h0);
        v = int'(d[23:0]);
        if (rst) begin
            exp_pin = 0;
            model_reset();
        end else begin
            exp_pin = m_en ? wave[0] : 1'b0;
            if (m_en) begin
                wave.delete(0);
                if (wave.size() == 0) begin
                    a_per = m_per; a_wid = m_wid; m_pend = 0;
                    refill();
                end
            end
            if (!c && we) begin
                case (a)
                    2'd0: begin
                        if (d[0] && !m_en) begin
                            a_per = m_per; a_wid = m_wid; m_pend = 0;
                            refill();
                        end
                        if (!d[0]) wave.delete();
                        m_en = d[0];
                    end
                    2'd1: begin m_per = (v < 2) ? 2 : v; m_pend = 1; end
                    2'd2: begin m_wid = wid_store(v); m_pend = 1; end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        pin_q.push_back(exp_pin);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 2'd3, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(0, 0, 1, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        cycle(0, 0, 0, a, 32'h0);
    endtask

    task automatic run_until_cnt(input int target);
        int k;
        k = 0;
        while (model_cnt() != target && k < 64) begin
            idle(1);
            k++;
        end
        if (model_cnt() != target) begin
            n_tests++; n_fail++;
            $display("FAIL wait_cnt: count %0d, required %0d", model_cnt(), target);
        end
    endtask

    // Monitor: compare whatever the scoreboard expects for this cycle.
    always @(negedge clk) begin
        if (rd_q.size() > 0) begin
            e_rd = rd_q.pop_front();
            n_tests++;
            if (rd_data !== e_rd) begin
                n_fail++;
                $display("FAIL rd_data: got %h, expected %h (t=%0t)", rd_data, e_rd, $time);
            end
        end
        if (pin_q.size() > 0) begin
            e_pin = pin_q.pop_front();
            n_tests++;
            if (m_servo !== e_pin) begin
                n_fail++;
                $display("FAIL m_servo: got %b, expected %b (t=%0t)", m_servo, e_pin, $time);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int sel;
        reset = 1'b1; cs = 1'b1; MemWrite = 1'b0; DataAdr = 2'd0; WriteData = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        cycle(1, 1, 0, 2'd0, 32'h0);
        cycle(1, 1, 0, 2'd0, 32'h0);
        for (int a = 0; a < 4; a++) rd(2'(a));

        // Enable: 3 high / 7 low, STATUS count sweep.
        wr(2'd0, 32'h1);
        idle(25);

        // Width change at cnt=4 stays pending until the wrap.
        run_until_cnt(4);
        wr(2'd2, 32'd5);
        idle(22);

        // Period floor, constant-high and constant-low corners.
        wr(2'd1, 32'd1);
        rd(2'd1);
        idle(15);
        wr(2'd2, 32'd0);
        idle(10);

        // Width clamp behaviour.
        wr(2'd2, 32'd9);
        rd(2'd2);
        wr(2'd2, 32'd1);
        rd(2'd2);

        // Disable mid-pulse.
        wr(2'd1, 32'd10);
        wr(2'd2, 32'd3);
        idle(14);
        run_until_cnt(1);
        wr(2'd0, 32'h0);
        idle(3);

        // Reset with a pending update and a simultaneous write.
        wr(2'd0, 32'h1);
        wr(2'd2, 32'd5);
        idle(2);
        cycle(1, 0, 1, 2'd1, 32'd7);
        for (int a = 0; a < 4; a++) rd(2'(a));

        // Deselected write and read-only STATUS.
        cycle(0, 1, 1, 2'd2, 32'd8);
        cycle(0, 1, 0, 2'd2, 32'h0);
        rd(2'd2);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3);
        rd(2'd0);

        // Randomised traffic.
        wr(2'd0, 32'h1);
        for (int i = 0; i < 500; i++) begin
            sel = int'($urandom_range(0, 99));
            d = $urandom;
            if (sel < 1) begin
                cycle(1, 0, 0, 2'd0, d);
            end else if (sel < 55) begin
                rd(2'($urandom_range(0, 3)));
            end else if (sel < 60) begin
                cycle(0, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d);
            end else if (sel < 68) begin
                d[0] = ($urandom_range(0, 3) != 0);
                wr(2'd0, d);
            end else if (sel < 80) begin
                d[23:0] = 24'($urandom_range(0, 12));
                wr(2'd1, d);
            end else if (sel < 95) begin
                d[23:0] = 24'($urandom_range(0, 14));
                wr(2'd2, d);
            end else begin
                wr(2'd3, d);
            end
        end
        idle(2);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
